// File: rtl/alu_exec_unit_if.sv
// Operand/control and result bundle for the ALU execute stage.
interface alu_exec_unit_if;
    logic        in_valid;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [5:0]  opcode;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] pc;
    logic [31:0] imm_ext;

    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    logic        sign;
    logic        overflow;
    logic [2:0]  alu_ctl;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;

    // Issuing side: drives operands, observes results.
    modport master (
        output in_valid, aluop, funct, opcode, opa, opb, pc, imm_ext,
        input  out_valid, result, zero, sign, overflow, alu_ctl, pc_plus4, branch_target
    );

    // Execute unit side.
    modport slave (
        input  in_valid, aluop, funct, opcode, opa, opb, pc, imm_ext,
        output out_valid, result, zero, sign, overflow, alu_ctl, pc_plus4, branch_target
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Single-cycle ALU execute stage: decodes the ALU operation, computes result,
// flags and PC-relative addresses, and registers them one cycle later.
module alu_exec_unit #(
    parameter logic [31:0] PC_INC = 32'd4
) (
    input logic             clk,
    input logic             rst_n,
    alu_exec_unit_if.slave  bus_io
);

    localparam logic [2:0] CtlAnd = 3'b000;
    localparam logic [2:0] CtlOr  = 3'b001;
    localparam logic [2:0] CtlAdd = 3'b010;
    localparam logic [2:0] CtlSub = 3'b110;
    localparam logic [2:0] CtlSlt = 3'b111;

    logic [2:0]  alu_ctl_d, alu_ctl_q;
    logic [31:0] result_d, result_q;
    logic        overflow_d, overflow_q;
    logic [31:0] pc_plus4_d, pc_plus4_q;
    logic [31:0] branch_target_d, branch_target_q;
    logic        zero_q, sign_q, out_valid_q;
    logic [31:0] sum, diff;

    // Only funct[3:0] takes part in R-type decode; the offset shift drops imm_ext[31:30].
    logic unused_bits;
    assign unused_bits = ^{bus_io.funct[5:4], bus_io.imm_ext[31:30]};

    // Decode the ALU operation from aluop, funct and opcode.
    always_comb begin
        alu_ctl_d = CtlAdd;
        case (bus_io.aluop)
            2'b00: alu_ctl_d = CtlAdd;
            2'b01: alu_ctl_d = CtlSub;
            2'b10: begin
                case (bus_io.funct[3:0])
                    4'b0000: alu_ctl_d = CtlAdd;
                    4'b0010: alu_ctl_d = CtlSub;
                    4'b0100: alu_ctl_d = CtlAnd;
                    4'b0101: alu_ctl_d = CtlOr;
                    4'b1010: alu_ctl_d = CtlSlt;
                    default: alu_ctl_d = CtlAdd;
                endcase
            end
            default: begin
                case (bus_io.opcode)
                    6'b001100: alu_ctl_d = CtlAnd;
                    6'b001101: alu_ctl_d = CtlOr;
                    6'b001010: alu_ctl_d = CtlSlt;
                    default:   alu_ctl_d = CtlAdd;
                endcase
            end
        endcase
    end

    assign sum  = bus_io.opa + bus_io.opb;
    assign diff = bus_io.opa - bus_io.opb;

    // Execute the decoded operation; overflow is only meaningful for ADD/SUB.
    always_comb begin
        result_d   = 32'd0;
        overflow_d = 1'b0;
        case (alu_ctl_d)
            CtlAnd: result_d = bus_io.opa & bus_io.opb;
            CtlOr:  result_d = bus_io.opa | bus_io.opb;
            CtlAdd: begin
                result_d   = sum;
                overflow_d = (bus_io.opa[31] == bus_io.opb[31]) && (sum[31] != bus_io.opa[31]);
            end
            CtlSub: begin
                result_d   = diff;
                overflow_d = (bus_io.opa[31] != bus_io.opb[31]) && (diff[31] != bus_io.opa[31]);
            end
            CtlSlt: result_d = {31'd0, $signed(bus_io.opa) < $signed(bus_io.opb)};
            default: result_d = 32'd0;
        endcase
    end

    // Sequential PC and word-scaled branch offset.
    always_comb begin
        pc_plus4_d      = bus_io.pc + PC_INC;
        branch_target_d = pc_plus4_d + {bus_io.imm_ext[29:0], 2'b00};
    end

    // Result registers load on a valid operation and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q     <= 1'b0;
            result_q        <= 32'd0;
            zero_q          <= 1'b0;
            sign_q          <= 1'b0;
            overflow_q      <= 1'b0;
            alu_ctl_q       <= 3'd0;
            pc_plus4_q      <= 32'd0;
            branch_target_q <= 32'd0;
        end else begin
            out_valid_q <= bus_io.in_valid;
            if (bus_io.in_valid) begin
                result_q        <= result_d;
                zero_q          <= (result_d == 32'd0);
                sign_q          <= result_d[31];
                overflow_q      <= overflow_d;
                alu_ctl_q       <= alu_ctl_d;
                pc_plus4_q      <= pc_plus4_d;
                branch_target_q <= branch_target_d;
            end
        end
    end

    assign bus_io.out_valid     = out_valid_q;
    assign bus_io.result        = result_q;
    assign bus_io.zero          = zero_q;
    assign bus_io.sign          = sign_q;
    assign bus_io.overflow      = overflow_q;
    assign bus_io.alu_ctl       = alu_ctl_q;
    assign bus_io.pc_plus4      = pc_plus4_q;
    assign bus_io.branch_target = branch_target_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with hand-computed expectations.
module tb_alu_exec_unit;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;

    alu_exec_unit_if bus ();

    alu_exec_unit #(.PC_INC(32'd4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check the ALU-side outputs of one captured operation.
    task automatic chk_alu(input string tag, input logic [31:0] res, input logic z,
                           input logic s, input logic ov, input logic [2:0] ctl);
        chk({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({tag, ".result"}, bus.result, res);
        chk({tag, ".zero"}, {31'd0, bus.zero}, {31'd0, z});
        chk({tag, ".sign"}, {31'd0, bus.sign}, {31'd0, s});
        chk({tag, ".ovf"}, {31'd0, bus.overflow}, {31'd0, ov});
        chk({tag, ".ctl"}, {29'd0, bus.alu_ctl}, {29'd0, ctl});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, ".result"}, bus.result, 32'd0);
        chk({tag, ".flags"}, {29'd0, bus.zero, bus.sign, bus.overflow}, 32'd0);
        chk({tag, ".ctl"}, {29'd0, bus.alu_ctl}, 32'd0);
        chk({tag, ".pc4"}, bus.pc_plus4, 32'd0);
        chk({tag, ".bt"}, bus.branch_target, 32'd0);
    endtask

    // Present one operation for a single edge, then drop in_valid.
    task automatic apply(input logic [1:0] aop, input logic [5:0] fn, input logic [5:0] opc,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pcv, input logic [31:0] imm);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.aluop    = aop;
        bus.funct    = fn;
        bus.opcode   = opc;
        bus.opa      = a;
        bus.opb      = b;
        bus.pc       = pcv;
        bus.imm_ext  = imm;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.aluop    = 2'b00;
        bus.funct    = 6'd0;
        bus.opcode   = 6'd0;
        bus.opa      = 32'd0;
        bus.opb      = 32'd0;
        bus.pc       = 32'd0;
        bus.imm_ext  = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // R-type add 5+7
        apply(2'b10, 6'b100000, 6'd0, 32'd5, 32'd7, 32'd0, 32'd0);
        chk_alu("radd", 32'd12, 1'b0, 1'b0, 1'b0, 3'b010);

        // Branch-compare subtract of equal operands
        apply(2'b01, 6'd0, 6'd0, 32'h1234, 32'h1234, 32'd0, 32'd0);
        chk_alu("beqsub", 32'd0, 1'b1, 1'b0, 1'b0, 3'b110);

        // Signed SLT both ways
        apply(2'b10, 6'b101010, 6'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
        chk_alu("slt_lt", 32'd1, 1'b0, 1'b0, 1'b0, 3'b111);
        apply(2'b10, 6'b101010, 6'd0, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0);
        chk_alu("slt_ge", 32'd0, 1'b1, 1'b0, 1'b0, 3'b111);

        // ADD wraparound without overflow, then signed overflow
        apply(2'b00, 6'd0, 6'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
        chk_alu("add_wrap", 32'd0, 1'b1, 1'b0, 1'b0, 3'b010);
        apply(2'b00, 6'd0, 6'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0);
        chk_alu("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b1, 3'b010);

        // SUB signed overflow: most-negative minus one
        apply(2'b10, 6'b100010, 6'd0, 32'h8000_0000, 32'd1, 32'd0, 32'd0);
        chk_alu("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 3'b110);

        // Only funct[3:0] matters: 110010 decodes as SUB
        apply(2'b10, 6'b110010, 6'd0, 32'd10, 32'd3, 32'd0, 32'd0);
        chk_alu("funct_lo", 32'd7, 1'b0, 1'b0, 1'b0, 3'b110);

        // jr funct falls back to ADD
        apply(2'b10, 6'b001000, 6'd0, 32'd2, 32'd3, 32'd0, 32'd0);
        chk_alu("jr", 32'd5, 1'b0, 1'b0, 1'b0, 3'b010);

        // PC arithmetic: backward branch by one word, and pc wrap
        apply(2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 32'h100, 32'hFFFF_FFFF);
        chk("pc4_a", bus.pc_plus4, 32'h104);
        chk("bt_a", bus.branch_target, 32'h100);
        apply(2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd3);
        chk("pc4_b", bus.pc_plus4, 32'd0);
        chk("bt_b", bus.branch_target, 32'd12);

        // I-type decode
        apply(2'b11, 6'd0, 6'b001100, 32'hF0F0, 32'hFF00, 32'd0, 32'd0);
        chk_alu("andi", 32'hF000, 1'b0, 1'b0, 1'b0, 3'b000);
        apply(2'b11, 6'd0, 6'b001101, 32'hF0F0, 32'hFF00, 32'd0, 32'd0);
        chk_alu("ori", 32'hFFF0, 1'b0, 1'b0, 1'b0, 3'b001);
        apply(2'b11, 6'd0, 6'b001010, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'd0);
        chk_alu("slti", 32'd1, 1'b0, 1'b0, 1'b0, 3'b111);
        apply(2'b11, 6'd0, 6'b001000, 32'd9, 32'd1, 32'd0, 32'd0);
        chk_alu("addi", 32'd10, 1'b0, 1'b0, 1'b0, 3'b010);

        // R-type AND / OR
        apply(2'b10, 6'b100100, 6'd0, 32'hF0F0, 32'hFF00, 32'd0, 32'd0);
        chk_alu("rand", 32'hF000, 1'b0, 1'b0, 1'b0, 3'b000);
        apply(2'b10, 6'b100101, 6'd0, 32'hF0F0, 32'hFF00, 32'h40, 32'd1);
        chk_alu("ror", 32'hFFF0, 1'b0, 1'b0, 1'b0, 3'b001);

        // Idle edge: out_valid drops, everything else holds
        @(posedge clk);
        #1;
        chk("hold.valid", {31'd0, bus.out_valid}, 32'd0);
        chk("hold.result", bus.result, 32'hFFF0);
        chk("hold.ctl", {29'd0, bus.alu_ctl}, 32'd1);
        chk("hold.bt", bus.branch_target, 32'h48);

        // Reset between edges during back-to-back ADDs
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.aluop    = 2'b00;
        bus.opa      = 32'd100;
        bus.opb      = 32'd1;
        bus.pc       = 32'h200;
        bus.imm_ext  = 32'd0;
        @(posedge clk);
        #1;
        chk("b2b1.result", bus.result, 32'd101);
        bus.opa = 32'd200;
        @(posedge clk);
        #1;
        chk("b2b2.result", bus.result, 32'd201);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst.valid", {31'd0, bus.out_valid}, 32'd0);
        chk("post_rst.result", bus.result, 32'd0);

        // First capture after release
        apply(2'b00, 6'd0, 6'd0, 32'd3, 32'd4, 32'd0, 32'd0);
        chk_alu("first_cap", 32'd7, 1'b0, 1'b0, 1'b0, 3'b010);
        chk("first_cap.pc4", bus.pc_plus4, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter PC_INC, default 4, constant added to pc to form pc_plus4.
REQ-002 clk  input  1  single clock, all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operands and controls valid this cycle.
REQ-005 aluop  input  2  {aluop1, aluop0} from the main control unit.
REQ-006 funct  input  6  instruction bits [5:0].
REQ-007 opcode  input  6  instruction bits [31:26].
REQ-008 opa  input  32  ALU operand A (register rs).
REQ-009 opb  input  32  ALU operand B (rt or sign-extended immediate).
REQ-010 pc  input  32  current program counter.
REQ-011 imm_ext  input  32  sign-extended branch offset, in words.
REQ-012 out_valid  output  1  registered results valid.
REQ-013 result  output  32  registered ALU result.
REQ-014 zero  output  1  registered flag, result == 0.
REQ-015 sign  output  1  registered result[31].
REQ-016 overflow  output  1  registered signed overflow of ADD/SUB.
REQ-017 alu_ctl  output  3  registered decoded ALU operation code.
REQ-018 pc_plus4  output  32  registered pc + PC_INC.
REQ-019 branch_target  output  32  registered pc + PC_INC + (imm_ext << 2).

Function
REQ-020 Decode alu_ctl combinationally: aluop=00 -> 010 (ADD); aluop=01 -> 110 (SUB).
REQ-021 aluop=10 (R-type) decodes funct[3:0] only: 0000 -> 010, 0010 -> 110, 0100 -> 000 (AND), 0101 -> 001 (OR), 1010 -> 111 (SLT), any other value (including jr 1000) -> 010.
REQ-022 aluop=11 (I-type) decodes opcode: 001100 -> 000, 001101 -> 001, 001010 -> 111, any other value -> 010.
REQ-023 Operations: 000 opa AND opb; 001 opa OR opb; 010 opa+opb mod 2^32; 110 opa-opb mod 2^32; 111 result 1 if opa < opb as signed two's complement, else 0; codes 011/100/101 give result 0.
REQ-024 overflow is 1 only for ADD/SUB with signed overflow (ADD: operand signs equal and result sign differs; SUB: operand signs differ and result sign differs from opa); 0 for all other operations; no trap.
REQ-025 zero = (result == 0) and sign = result[31], computed from the same result that is registered.
REQ-026 pc_plus4 = pc + PC_INC and branch_target = pc_plus4 + (imm_ext << 2), both mod 2^32 with no carry out.
REQ-027 Latency is exactly one cycle: on a rising edge with in_valid=1, all result registers load and out_valid becomes 1.
REQ-028 On a rising edge with in_valid=0, out_valid becomes 0 and all other output registers hold their values.
REQ-029 There is no backpressure: a new operation can be accepted every cycle.

Reset
REQ-030 While rst_n=0, all outputs are 0 immediately, independent of clk, including out_valid, result, zero, sign, overflow, alu_ctl, pc_plus4 and branch_target.
REQ-031 An operation in flight when reset asserts is discarded.
REQ-032 The first capture after reset release happens on the first rising edge with rst_n=1 and in_valid=1.

Verification
REQ-033 aluop=10, funct=100000, opa=5, opb=7 -> next cycle: result=12, alu_ctl=010, zero=0, out_valid=1.
REQ-034 aluop=01, opa=opb=0x00001234 -> result=0, zero=1, alu_ctl=110, overflow=0.
REQ-035 aluop=10, funct=101010, opa=0xFFFFFFFF, opb=1 -> result=1; opa=1, opb=0xFFFFFFFF -> result=0.
REQ-036 ADD 0xFFFFFFFF+1 -> result=0, zero=1, overflow=0; ADD 0x7FFFFFFF+1 -> result=0x80000000, sign=1, overflow=1.
REQ-037 pc=0x100, imm_ext=0xFFFFFFFF -> pc_plus4=0x104, branch_target=0x100; pc=0xFFFFFFFC -> pc_plus4=0.
REQ-038 Reset case: drive valid ADD operations back-to-back, assert rst_n=0 between clock edges -> all outputs go to 0 at once; deassert with in_valid=0 -> out_valid stays 0.
